// File: rtl/ram_dump_reader.sv
// ram_dump_reader
//
// Walks a contiguous range of RAM words through a combinational read port.
// Each word is split into bytes, most significant byte first, and streamed
// to a byte transmitter over a valid/ready handshake. The block is used to
// dump program or data memory back to the host.
//
// Ports:
//   i_clock          rising-edge clock
//   i_reset_n        asynchronous active-low reset, clears all state
//   i_start          start command, accepted only while idle
//   i_base_address   first word address, latched on an accepted start
//   i_word_count     number of words to dump (0 .. 2^NB_ADDR), latched on start
//   o_read_enable    RAM read enable, high only in the fetch cycle
//   o_read_address   RAM read address (current address register)
//   i_read_data      RAM read data, valid in the same cycle as the address
//   o_tx_data        byte presented to the transmitter
//   o_tx_valid       byte available
//   i_tx_ready       transmitter accepts the byte
//   o_busy           high whenever a dump is in progress
//   o_done           one-cycle pulse when a dump completes
module ram_dump_reader #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 10,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_base_address,
  input  logic [NB_ADDR:0]   i_word_count,
  output logic               o_read_enable,
  output logic [NB_ADDR-1:0] o_read_address,
  input  logic [NB_DATA-1:0] i_read_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [NB_IDX-1:0]  IDX_ONE  = NB_IDX'(1);
  localparam logic [NB_IDX-1:0]  IDX_LAST = NB_IDX'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] ADDR_ONE = NB_ADDR'(1);
  localparam logic [NB_ADDR:0]   CNT_ZERO = '0;
  localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_ADDR:0]    remaining_q, remaining_d;
  logic [NB_DATA-1:0]  word_q, word_d;
  logic [NB_IDX-1:0]   byte_idx_q, byte_idx_d;

  logic tx_fire;
  logic last_byte;

  // Outputs are pure register decodes, so i_tx_ready only matters at the edge.
  assign tx_fire   = (state_q == S_SEND) && i_tx_ready;
  assign last_byte = (byte_idx_q == IDX_LAST);

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (i_word_count == CNT_ZERO) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (tx_fire && last_byte) begin
          state_d = (remaining_q == CNT_ONE) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: address, word counter, byte shifter
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d      = i_base_address;
          remaining_d = i_word_count;
        end
      end
      S_FETCH: begin
        word_d     = i_read_data;
        byte_idx_d = '0;
      end
      S_SEND: begin
        if (tx_fire) begin
          if (!last_byte) begin
            word_d     = word_q << NB_BYTE;
            byte_idx_d = byte_idx_q + IDX_ONE;
          end else begin
            remaining_d = remaining_q - CNT_ONE;
            // Address advances only when another word follows; the natural
            // overflow of the register gives the wrap to address 0.
            if (remaining_q != CNT_ONE) begin
              addr_d = addr_q + ADDR_ONE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

  // Output decode
  always_comb begin
    o_read_enable  = (state_q == S_FETCH);
    o_read_address = addr_q;
    o_tx_valid     = (state_q == S_SEND);
    // The word register only shifts on a transfer, so the byte holds under
    // backpressure without extra storage.
    o_tx_data      = word_q[NB_DATA-1 -: NB_BYTE];
    o_busy         = (state_q != S_IDLE);
    o_done         = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
module tb_ram_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        read_en;
  logic [9:0]  read_addr;
  logic [15:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ready;
  logic        busy;
  logic        done;

  logic [15:0] ram [0:1023];

  int checks = 0;
  int errors = 0;

  logic [7:0] q_bytes [$];
  logic [9:0] q_addr  [$];
  int done_cycle;
  int done_pulses;

  always #5 clk = ~clk;

  assign read_data = ram[read_addr];

  ram_dump_reader #(.NB_DATA(16), .NB_ADDR(10), .NB_BYTE(8)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_start        (start),
    .i_base_address (base_addr),
    .i_word_count   (word_count),
    .o_read_enable  (read_en),
    .o_read_address (read_addr),
    .i_read_data    (read_data),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (ready),
    .o_busy         (busy),
    .o_done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a dump and observes it cycle by cycle (sampling on the falling
  // edge) until o_done has pulsed and dropped again.
  task automatic run_dump(input logic [9:0] base, input logic [10:0] cnt,
                          input int stall_from, input int stall_n,
                          input logic [7:0] stall_byte,
                          input int ign_at, input int budget);
    int cyc;
    bit done_seen;
    bit finished;
    q_bytes.delete();
    q_addr.delete();
    done_cycle  = -1;
    done_pulses = 0;
    done_seen   = 1'b0;
    finished    = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    ready      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!finished && cyc <= budget) begin
      start = (cyc == ign_at);
      if (cyc == ign_at) begin
        base_addr  = 10'd100;
        word_count = 11'd5;
      end
      ready = 1'b1;
      if (cyc >= stall_from && cyc < stall_from + stall_n) begin
        ready = 1'b0;
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_byte);
      end
      if (read_en) q_addr.push_back(read_addr);
      if (tx_valid && ready) q_bytes.push_back(tx_data);
      if (done) begin
        done_pulses++;
        if (!done_seen) done_cycle = cyc;
        done_seen = 1'b1;
      end else if (done_seen) begin
        check("idle_busy", busy, 0);
        finished = 1'b1;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    check("completed", finished, 1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp [$]);
    check({tag, "_len"}, q_bytes.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < q_bytes.size()) check(tag, q_bytes[i], exp[i]);
    end
  endtask

  task automatic check_addrs(input string tag, input logic [9:0] exp [$]);
    check({tag, "_len"}, q_addr.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < q_addr.size()) check(tag, q_addr[i], exp[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] eb [$];
    logic [9:0] ea [$];
    int nw;

    for (int i = 0; i < 1024; i++) ram[i] = 16'((i * 40503 + 4660) & 16'hFFFF);
    ram[4]    = 16'hA1B2;
    ram[5]    = 16'hC3D4;
    ram[1023] = 16'h1234;
    ram[0]    = 16'h5678;

    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    ready      = 1'b1;

    // Reset state
    #1;
    check("rst_read_en", read_en, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic dump
    run_dump(10'd4, 11'd2, 0, 0, 8'h00, 0, 50);
    eb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ea = '{10'd4, 10'd5};
    check_bytes("basic_byte", eb);
    check_addrs("basic_addr", ea);
    check("basic_done_cycle", done_cycle, 7);
    check("basic_done_pulses", done_pulses, 1);

    // Backpressure while B2 is presented (cycles 3..5)
    run_dump(10'd4, 11'd2, 3, 3, 8'hB2, 0, 50);
    check_bytes("bp_byte", eb);
    check("bp_done_cycle", done_cycle, 10);
    check("bp_done_pulses", done_pulses, 1);

    // Address wrap
    run_dump(10'd1023, 11'd2, 0, 0, 8'h00, 0, 50);
    eb = '{8'h12, 8'h34, 8'h56, 8'h78};
    ea = '{10'd1023, 10'd0};
    check_bytes("wrap_byte", eb);
    check_addrs("wrap_addr", ea);
    check("wrap_done_cycle", done_cycle, 7);

    // Zero count
    run_dump(10'd7, 11'd0, 0, 0, 8'h00, 0, 20);
    check("zero_bytes", q_bytes.size(), 0);
    check("zero_reads", q_addr.size(), 0);
    check("zero_done_cycle", done_cycle, 1);
    check("zero_done_pulses", done_pulses, 1);

    // Full-memory dump checked word by word against the RAM model
    run_dump(10'd0, 11'd1024, 0, 0, 8'h00, 0, 3300);
    check("full_len", q_bytes.size(), 2048);
    check("full_reads", q_addr.size(), 1024);
    check("full_done_cycle", done_cycle, 3073);
    nw = q_bytes.size() / 2;
    if (nw > 1024) nw = 1024;
    for (int w = 0; w < nw; w++) begin
      check("full_word", {q_bytes[2*w], q_bytes[2*w+1]}, ram[w]);
    end

    // Start pulsed mid-dump must be ignored
    run_dump(10'd4, 11'd2, 0, 0, 8'h00, 3, 50);
    eb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ea = '{10'd4, 10'd5};
    check_bytes("ign_byte", eb);
    check_addrs("ign_addr", ea);
    check("ign_done_cycle", done_cycle, 7);

    // Reset mid-word: start, reach the second byte of the first word
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 10'd4;
    word_count = 11'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_before_rst", tx_valid, 1);
    check("mid_data_before_rst", tx_data, 8'hB2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read_en", read_en, 0);
    check("mid_rst_addr", read_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_dump(10'd0, 11'd1, 0, 0, 8'h00, 0, 50);
    eb = '{8'h56, 8'h78};
    ea = '{10'd0};
    check_bytes("after_rst_byte", eb);
    check_addrs("after_rst_addr", ea);
    check("after_rst_done_cycle", done_cycle, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
